// File: rtl/gfifo_step_pkg.sv
// Shared types and default sizing for the gfifo step scheduler.
package gfifo_step_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_ISSUE   = 2'd2,
    S_STOPPED = 2'd3
  } step_state_e;

  localparam int unsigned DEF_NUM_CORE        = 2;
  localparam int unsigned DEF_STEP_WIDTH      = 8;
  localparam int unsigned DEF_ACC_WIDTH       = 16;
  localparam int unsigned DEF_BATCH_THRESHOLD = 64;
  localparam int unsigned DEF_FLUSH_TIMEOUT   = 255;
  localparam int unsigned DEF_POLL_PERIOD     = 5000;
endpackage

// File: rtl/gfifo_step_scheduler_if.sv
// Requester lanes, batch output and poll handshake of the step scheduler.
interface gfifo_step_scheduler_if #(
  parameter int unsigned NUM_CORE   = 2,
  parameter int unsigned STEP_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16
);
  logic [NUM_CORE*STEP_WIDTH-1:0] in_step;
  logic                           in_ready;
  logic                           out_valid;
  logic [ACC_WIDTH-1:0]           out_step;
  logic                           out_ready;
  logic                           poll_req;
  logic                           poll_resp_valid;
  logic                           poll_resp_hit;
  logic                           stopped;

  modport master (
    output in_step, out_ready, poll_resp_valid, poll_resp_hit,
    input  in_ready, out_valid, out_step, poll_req, stopped
  );

  modport slave (
    input  in_step, out_ready, poll_resp_valid, poll_resp_hit,
    output in_ready, out_valid, out_step, poll_req, stopped
  );
endinterface

// File: rtl/gfifo_poll_timer.sv
// Free-running poll pulse generator; freezes and stays silent while en_i is low.
module gfifo_poll_timer #(
  parameter int unsigned POLL_PERIOD = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  output logic poll_req_o
);
  localparam int unsigned CW = $clog2(POLL_PERIOD + 1);

  logic [CW-1:0] cnt_q;
  logic          poll_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      poll_q <= 1'b0;
    end else begin
      poll_q <= 1'b0;
      if (en_i) begin
        if (cnt_q == CW'(POLL_PERIOD - 1)) begin
          cnt_q  <= '0;
          poll_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // a pulse registered in the same cycle the stop lands must not escape
  assign poll_req_o = poll_q & en_i;
endmodule

// File: rtl/gfifo_step_scheduler.sv
// Batches per-core simulation steps into gfifo pushes and polls for the result.
// Optional GFIFO_STEP_STATS_EN adds stat_total_steps / stat_batches counters.
module gfifo_step_scheduler
  import gfifo_step_pkg::*;
#(
  parameter int unsigned NUM_CORE        = DEF_NUM_CORE,
  parameter int unsigned STEP_WIDTH      = DEF_STEP_WIDTH,
  parameter int unsigned ACC_WIDTH       = DEF_ACC_WIDTH,
  parameter int unsigned BATCH_THRESHOLD = DEF_BATCH_THRESHOLD,
  parameter int unsigned FLUSH_TIMEOUT   = DEF_FLUSH_TIMEOUT,
  parameter int unsigned POLL_PERIOD     = DEF_POLL_PERIOD
) (
  input  logic                  clock,
  input  logic                  reset,
  gfifo_step_scheduler_if.slave bus
`ifdef GFIFO_STEP_STATS_EN
  ,
  output logic [63:0]           stat_total_steps,
  output logic [31:0]           stat_batches
`endif
);
  localparam int unsigned FT_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [63:0] ACC_MAX  = (64'd1 << ACC_WIDTH) - 64'd1;
  localparam logic [63:0] LANE_MAX = 64'(NUM_CORE) * ((64'd1 << STEP_WIDTH) - 64'd1);
  // highest acc that can still absorb a full-scale lane sum without wrapping
  localparam logic [ACC_WIDTH-1:0] ACC_LIMIT = ACC_WIDTH'(ACC_MAX - LANE_MAX);

  step_state_e          state_q;
  logic [ACC_WIDTH-1:0] acc_q, out_step_q, lane_sum, acc_sum;
  logic [FT_W-1:0]      flush_q;
  logic                 out_valid_q, stopped_q;
  logic                 in_ready, stop_now, poll_en;

  assign in_ready = stopped_q | (acc_q <= ACC_LIMIT);
  assign stop_now = stopped_q | (bus.poll_resp_valid & bus.poll_resp_hit);
  assign acc_sum  = acc_q + lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < int'(NUM_CORE); i++)
      lane_sum = lane_sum + ACC_WIDTH'(bus.in_step[i*STEP_WIDTH +: STEP_WIDTH]);
    if (!in_ready) lane_sum = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      out_step_q  <= '0;
      out_valid_q <= 1'b0;
      flush_q     <= '0;
      stopped_q   <= 1'b0;
    end else begin
      if (bus.poll_resp_valid && bus.poll_resp_hit) stopped_q <= 1'b1;
      flush_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (stop_now) begin
            state_q <= S_STOPPED;
            acc_q   <= '0;
          end else begin
            acc_q <= acc_sum;
            if (acc_sum != '0) state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (stop_now) begin
            state_q <= S_STOPPED;
            acc_q   <= '0;
          end else if (acc_q >= ACC_WIDTH'(BATCH_THRESHOLD) ||
                       flush_q == FT_W'(FLUSH_TIMEOUT)) begin
            out_step_q  <= acc_q;
            out_valid_q <= 1'b1;
            acc_q       <= lane_sum;
            state_q     <= S_ISSUE;
          end else begin
            acc_q   <= acc_sum;
            flush_q <= flush_q + FT_W'(1);
          end
        end
        S_ISSUE: begin
          // once stopping, accepted lanes are discarded so acc cannot wrap
          acc_q <= stop_now ? '0 : acc_sum;
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (stop_now)            state_q <= S_STOPPED;
            else if (acc_sum != '0)  state_q <= S_ACCUM;
            else                     state_q <= S_IDLE;
          end
        end
        S_STOPPED: acc_q <= '0;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign poll_en = ~stopped_q;

  gfifo_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_poll (
    .clock      (clock),
    .reset      (reset),
    .en_i       (poll_en),
    .poll_req_o (bus.poll_req)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_step  = out_step_q;
  assign bus.stopped   = stopped_q;

`ifdef GFIFO_STEP_STATS_EN
  logic [63:0] stat_total_q;
  logic [31:0] stat_batches_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_total_q   <= '0;
      stat_batches_q <= '0;
    end else if (state_q == S_ISSUE && bus.out_ready) begin
      stat_total_q   <= stat_total_q + 64'(out_step_q);
      stat_batches_q <= stat_batches_q + 32'd1;
    end
  end

  assign stat_total_steps = stat_total_q;
  assign stat_batches     = stat_batches_q;
`endif
endmodule

// File: tb/tb_gfifo_step_scheduler.sv
// Bench for gfifo_step_scheduler: directed scenarios plus random traffic against a step-level model.
module tb_gfifo_step_scheduler;
  localparam int NC = 2, SW = 8, AW = 16, TH = 64, FT = 255, PP = 5000;
  localparam longint LIMIT = ((64'd1 << AW) - 1) - NC * ((64'd1 << SW) - 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gfifo_step_scheduler_if #(.NUM_CORE(NC), .STEP_WIDTH(SW), .ACC_WIDTH(AW)) bus ();

`ifdef GFIFO_STEP_STATS_EN
  logic [63:0] stat_total_steps;
  logic [31:0] stat_batches;
`endif

  gfifo_step_scheduler #(
    .NUM_CORE(NC), .STEP_WIDTH(SW), .ACC_WIDTH(AW),
    .BATCH_THRESHOLD(TH), .FLUSH_TIMEOUT(FT), .POLL_PERIOD(PP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef GFIFO_STEP_STATS_EN
    ,
    .stat_total_steps (stat_total_steps),
    .stat_batches     (stat_batches)
`endif
  );

  int tests = 0, fails = 0;
  int lane [NC];
  // model: steps held, pending batch, flush age, stop flags, cycle since reset
  longint m_acc, m_batch;
  logic [63:0] m_tot;
  logic [31:0] m_nb;
  int m_timer, m_cyc;
  bit m_pend, m_stop, m_halt;
  int first_v, nvalid, npoll;
  logic [63:0] first_step;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic drive(input int a, input int b, input bit ordy, input bit pv, input bit ph);
    lane[0] = a; lane[1] = b;
    bus.in_step         = {8'(b), 8'(a)};
    bus.out_ready       = ordy;
    bus.poll_resp_valid = pv;
    bus.poll_resp_hit   = ph;
  endtask

  task automatic do_reset();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    m_acc = 0; m_batch = 0; m_tot = '0; m_nb = '0; m_timer = 0; m_cyc = 0;
    m_pend = 0; m_stop = 0; m_halt = 0;
    first_v = -1; nvalid = 0; npoll = 0; first_step = '0;
  endtask

  // compare one cycle at the falling edge, then advance the model with this cycle's inputs
  task automatic tick();
    longint acc_in;
    bit rdy, stop_now;
    @(negedge clock);
    rdy = m_stop || (m_acc <= LIMIT);
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, m_pend);
    chk("out_step", bus.out_step, m_batch);
    chk("stopped", bus.stopped, m_stop);
    chk("poll_req", bus.poll_req, (m_cyc > 0 && m_cyc % PP == 0 && !m_stop));
`ifdef GFIFO_STEP_STATS_EN
    chk("stat_total", stat_total_steps, m_tot);
    chk("stat_batches", stat_batches, m_nb);
`endif
    if (bus.out_valid === 1'b1 && first_v < 0) begin
      first_v = m_cyc; first_step = bus.out_step;
    end
    if (bus.out_valid === 1'b1) nvalid++;
    if (bus.poll_req === 1'b1) npoll++;

    acc_in   = rdy ? longint'(lane[0] + lane[1]) : 0;
    stop_now = m_stop || (bus.poll_resp_valid && bus.poll_resp_hit);
    if (m_halt) m_acc = 0;
    else if (m_pend) begin
      if (bus.out_ready) begin
        m_pend = 0; m_tot += 64'(m_batch); m_nb += 1; m_halt = stop_now;
      end
      m_acc = stop_now ? 0 : m_acc + acc_in;
      m_timer = 0;
    end else if (stop_now) begin
      m_halt = 1; m_acc = 0;
    end else if (m_acc != 0 && (m_acc >= TH || m_timer == FT)) begin
      m_pend = 1; m_batch = m_acc; m_acc = acc_in; m_timer = 0;
    end else begin
      m_timer = (m_acc == 0) ? 0 : ((m_timer < FT) ? m_timer + 1 : FT);
      m_acc += acc_in;
    end
    if (bus.poll_resp_valid && bus.poll_resp_hit) m_stop = 1;
    m_cyc++;
    @(posedge clock); #1;
  endtask

  function automatic int rlane(input bit heavy);
    if (heavy) return $urandom_range(200, 255);
    case ($urandom_range(0, 3))
      0, 1:    return 0;
      2:       return $urandom_range(1, 3);
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  initial begin
    // steady 1+1: first batch of 64 on cycle 33, single-cycle valid
    do_reset();
    drive(1, 1, 1'b1, 1'b0, 1'b0);
    repeat (40) tick();
    chk("r027_first_cycle", 64'(first_v), 64'd33);
    chk("r027_step", first_step, 64'd64);
    chk("r027_pulses", 64'(nvalid), 64'd1);

    // lone 3 steps flushed by timeout
    do_reset();
    drive(3, 0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    repeat (270) tick();
    chk("r028_first_cycle", 64'(first_v), 64'd257);
    chk("r028_step", first_step, 64'd3);
    chk("r028_pulses", 64'(nvalid), 64'd1);

    // backpressure with full-scale lanes: throttle, no wrap, batch stable
    do_reset();
    drive(255, 255, 1'b0, 1'b0, 1'b0);
    repeat (140) tick();
    chk("r029_in_ready_low", bus.in_ready, 64'd0);
    chk("r029_step_held", bus.out_step, 64'd510);
    drive(255, 255, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();

    // stop while a batch waits on out_ready
    do_reset();
    drive(40, 40, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(7, 9, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    chk("r030_valid_held", bus.out_valid, 64'd1);
    chk("r030_stopped", bus.stopped, 64'd1);
    drive(7, 9, 1'b1, 1'b0, 1'b0);
    tick();
    nvalid = 0;
    repeat (30) tick();
    chk("r030_no_reassert", 64'(nvalid), 64'd0);

    // random mixed traffic, late stop
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(rlane(1'b0), rlane(1'b0), $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0, (i > 2500) && ($urandom_range(0, 3) == 0));
      tick();
    end

    // random heavy traffic with rare out_ready
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive(rlane(1'b1), rlane(1'b1), $urandom_range(0, 19) == 0, 1'b0, 1'b0);
      tick();
    end

    // idle run: polls on cycles 5000 and 10000 only
    do_reset();
    repeat (10001) tick();
    chk("r031_poll_count", 64'(npoll), 64'd2);

`ifdef GFIFO_STEP_STATS_EN
    do_reset();
    for (int b = 0; b < 2; b++) begin
      drive(32, 32, 1'b1, 1'b0, 1'b0);
      tick();
      drive(0, 0, 1'b1, 1'b0, 1'b0);
      repeat (3) tick();
    end
    drive(5, 5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    repeat (270) tick();
    chk("r032_total", stat_total_steps, 64'd138);
    chk("r032_batches", 64'(stat_batches), 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
